counter_tx_top2: RTL and testbench
==================================

// Module: counter_tx_top2
// PURPOSE
//  Cache performance-monitor block. Eight per-cycle event counters (L1I, L1D, L2 read/write/miss) count while the CPU runs.
//  On cpu_done the counts are frozen and sent once over a UART TX line (8N1) to the host.
//  Sits beside the CPU/cache hierarchy; tx_data drives the board UART pin.
// PARAMETERS
//  CNT_W         32  width of each event counter (bits, multiple of 8)
//  CLKS_PER_BIT  64  clk cycles per UART bit; 1 byte frame = 10*CLKS_PER_BIT cycles
//  N_EVT         8   number of event counters (fixed; port list below)
// PORTS
//  clk          in   1  system clock, rising edge
//  rstn         in   1  synchronous active-low reset
//  read_C_L1I   in   1  event 0: CPU read of L1I this cycle
//  miss_L1I_C   in   1  event 1: L1I miss
//  read_C_L1D   in   1  event 2: CPU read of L1D
//  write_C_L1D  in   1  event 3: CPU write of L1D
//  miss_L1D_C   in   1  event 4: L1D miss
//  read_L1_L2   in   1  event 5: L1 read request to L2
//  write_L1_L2  in   1  event 6: L1 write(back) to L2
//  miss_L2_L1   in   1  event 7: L2 miss
//  cpu_done     in   1  level; program finished, triggers dump
//  tx_data      out  1  UART serial output, idle high
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): all counters=0, FSM=IDLE, tx_data=1, done flag cleared. Reset wins over everything, including mid-frame.
//  Counting: each clk edge with rstn=1 and cpu_done=0, counter[i] += 1 for every event input i sampled high (level, not edge).
//   All inputs are independent; simultaneous events each increment their own counter. Counters wrap modulo 2^CNT_W.
//  Counter bank is a submodule instance u_counter; its output register data_o holds the currently selected byte.
//  Freeze: once cpu_done is sampled high, counters stop (hold value); no further increments until reset.
//  FSM: IDLE -> LOAD -> START -> DATA -> STOP -> (next byte: LOAD | all sent: DONE).
//   IDLE: tx_data=1; go LOAD on first cycle cpu_done=1.
//   LOAD: 1 cycle; select byte k (k=0..N_EVT*CNT_W/8-1), latch into shift reg.
//   START: tx_data=0 for CLKS_PER_BIT cycles.
//   DATA: 8 bits LSB first, each CLKS_PER_BIT cycles.
//   STOP: tx_data=1 for CLKS_PER_BIT cycles; k++.
//   DONE: tx_data=1 forever; cpu_done staying high or toggling does NOT retrigger; only reset re-arms.
//  Byte order: counter 0..7 in port order; within a counter, MSB byte first (big-endian). 32 bytes total at defaults.
//  Latency: first start bit begins 2 cycles after cpu_done sampled high. Full dump = 32*(10*64+1) = 20512 cycles at defaults.
//  No gaps other than the 1-cycle LOAD between frames; no parity; no flow control.
//  cpu_done asserted during reset: ignored until rstn=1.
// TESTING
//  Reset 100 cycles -> tx_data=1 throughout, all counters 0.
//  Directed mix (10-cycle phases): read_C_L1I x4 phases, miss_L1I_C x2, read_C_L1D x3, write_C_L1D x2, miss_L1D_C x5, read_L1_L2 x2, write_L1_L2 x2
//   -> counts 40,20,30,20,50,20,20,0 (0x28,0x14,0x1E,0x14,0x32,0x14,0x14,0x00).
//  cpu_done=1 then decode UART at CLKS_PER_BIT=64 -> 32 bytes: 00 00 00 28, 00 00 00 14, 00 00 00 1E, ... 00 00 00 00; tx idle high after.
//  Events asserted after cpu_done -> counts and transmitted bytes unchanged.
//  rstn pulsed low mid-frame -> tx_data=1 next cycle, counters 0, new cpu_done restarts dump from byte 0.
//  All 8 events high simultaneously for 300 cycles -> each counter = 300 (0x0000012C).

Source files
------------

// File: rtl/counter_tx_top2.sv
// rtl/counter_tx_top2.sv - cache event counters dumped big-endian over an 8N1 UART line
//
// counter_bank: N_EVT saturating-free (wrapping) event counters with a registered byte selector.
//   clk, rstn      clock, synchronous active-low reset
//   cnt_en         count enable (low once the dump has been requested)
//   evt            one level-sensitive event bit per counter
//   sel            byte index; counter sel/BPC, byte sel%BPC with byte 0 = MSB
//   data_o         registered copy of the selected byte
//
// counter_tx_top2: counts cache events until cpu_done, then transmits every counter byte once.
//   clk, rstn      clock, synchronous active-low reset
//   read_C_L1I .. miss_L2_L1   event inputs 0..7
//   cpu_done       level, freezes counters and starts the one-shot dump
//   tx_data        UART serial output, idle high

module counter_bank #(
    parameter int CNT_W = 32,
    parameter int N_EVT = 8,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cnt_en,
    input  logic [N_EVT-1:0] evt,
    input  logic [SEL_W-1:0] sel,
    output logic [7:0]       data_o
);
    localparam int BPC = CNT_W / 8;

    logic [CNT_W-1:0] cnt [N_EVT];
    logic [7:0]       sel_byte;

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < N_EVT; i++) begin
            for (int b = 0; b < BPC; b++) begin
                if (int'(sel) == i * BPC + b) begin
                    sel_byte = cnt[i][(BPC - 1 - b) * 8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N_EVT; i++) begin
                cnt[i] <= '0;
            end
            data_o <= 8'h00;
        end else begin
            if (cnt_en) begin
                for (int i = 0; i < N_EVT; i++) begin
                    if (evt[i]) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
            data_o <= sel_byte;
        end
    end
endmodule

module counter_tx_top2 #(
    parameter int CNT_W        = 32,
    parameter int CLKS_PER_BIT = 64,
    parameter int N_EVT        = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic read_C_L1I,
    input  logic miss_L1I_C,
    input  logic read_C_L1D,
    input  logic write_C_L1D,
    input  logic miss_L1D_C,
    input  logic read_L1_L2,
    input  logic write_L1_L2,
    input  logic miss_L2_L1,
    input  logic cpu_done,
    output logic tx_data
);
    localparam int NB     = N_EVT * CNT_W / 8;
    localparam int SEL_W  = $clog2(NB);
    localparam int K_W    = $clog2(NB + 1);
    localparam int CCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [CCNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [K_W-1:0]    k, k_n;
    logic [7:0]        shreg, shreg_n;
    logic              tx_n;
    logic              frozen;
    logic              bit_end;
    logic [7:0]        byte_data;
    logic [N_EVT-1:0]  evt;

    assign evt = {miss_L2_L1, write_L1_L2, read_L1_L2, miss_L1D_C,
                  write_C_L1D, read_C_L1D, miss_L1I_C, read_C_L1I};

    // Counting stops on the very edge cpu_done is first seen, and stays stopped
    // even if cpu_done later drops.
    counter_bank #(
        .CNT_W (CNT_W),
        .N_EVT (N_EVT),
        .SEL_W (SEL_W)
    ) u_counter (
        .clk    (clk),
        .rstn   (rstn),
        .cnt_en (!cpu_done && !frozen),
        .evt    (evt),
        .sel    (k[SEL_W-1:0]),
        .data_o (byte_data)
    );

    assign bit_end = (clk_cnt == CCNT_W'(CLKS_PER_BIT - 1));

    // k advances on entry to STOP so the registered byte selector has settled
    // long before the next LOAD samples it.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_idx_n = bit_idx;
        k_n       = k;
        shreg_n   = shreg;
        tx_n      = 1'b1;
        case (state)
            IDLE: begin
                if (cpu_done) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                shreg_n   = byte_data;
                clk_cnt_n = '0;
                state_n   = START;
            end
            START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                tx_n = shreg[0];
                if (bit_end) begin
                    clk_cnt_n = '0;
                    shreg_n   = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        k_n     = k + 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = (k == K_W'(NB)) ? DONE : LOAD;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // tx_data is registered off the current state, so the line trails the FSM
    // by one cycle; this places the first start bit two cycles after cpu_done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            k       <= '0;
            shreg   <= 8'h00;
            frozen  <= 1'b0;
            tx_data <= 1'b1;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_idx <= bit_idx_n;
            k       <= k_n;
            shreg   <= shreg_n;
            frozen  <= frozen | cpu_done;
            tx_data <= tx_n;
        end
    end
endmodule

// File: tb/tb_counter_tx_top2.sv
// tb/tb_counter_tx_top2.sv - self-checking bench: UART decode of the counter dump against tables and a model
module tb_counter_tx_top2;
    localparam int CPB = 64;
    localparam int NB  = 32;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] evt;
    logic       cpu_done;
    logic       tx_data;

    int errors = 0;
    int checks = 0;

    int unsigned mcnt [8];
    bit          mfrozen;
    logic [7:0]  exp_b [NB];

    typedef struct {
        logic [7:0] mask;
        int         cycles;
    } phase_t;

    phase_t      ph [7];
    int unsigned dir_cnt [8];
    int unsigned all_cnt [8];

    always #5 clk = ~clk;

    counter_tx_top2 #(
        .CNT_W        (32),
        .CLKS_PER_BIT (CPB),
        .N_EVT        (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .read_C_L1I  (evt[0]),
        .miss_L1I_C  (evt[1]),
        .read_C_L1D  (evt[2]),
        .write_C_L1D (evt[3]),
        .miss_L1D_C  (evt[4]),
        .read_L1_L2  (evt[5]),
        .write_L1_L2 (evt[6]),
        .miss_L2_L1  (evt[7]),
        .cpu_done    (cpu_done),
        .tx_data     (tx_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one cycle of events from a negedge; the model sees the same posedge.
    task automatic tick(input logic [7:0] m);
        evt = m;
        @(negedge clk);
        if (!rstn) begin
            for (int i = 0; i < 8; i++) mcnt[i] = 0;
            mfrozen = 1'b0;
        end else begin
            if (!cpu_done && !mfrozen) begin
                for (int i = 0; i < 8; i++) begin
                    if (m[i]) mcnt[i] = mcnt[i] + 1;
                end
            end
            if (cpu_done) mfrozen = 1'b1;
        end
    endtask

    task automatic set_exp(input int unsigned c [8]);
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 4; b++) begin
                exp_b[i * 4 + b] = 8'((c[i] >> (24 - 8 * b)) & 32'hFF);
            end
        end
    endtask

    // Waits for a start bit (bounded), checks the idle gap before it, samples mid-bit.
    task automatic recv_frame(input string tag, input int exp_gap, output logic [7:0] b);
        int n = 0;
        b = 8'h00;
        while (tx_data !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx_data !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no start bit within %0d cycles", tag, n);
            return;
        end
        if (exp_gap >= 0) check({tag, "_gap"}, n, exp_gap);
        repeat (CPB / 2) @(negedge clk);
        check({tag, "_start"}, {31'd0, tx_data}, 32'd0);
        for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clk);
            b[j] = tx_data;
        end
        repeat (CPB) @(negedge clk);
        check({tag, "_stop"}, {31'd0, tx_data}, 32'd1);
    endtask

    task automatic recv_dump(input string tag);
        logic [7:0] b;
        for (int k = 0; k < NB; k++) begin
            recv_frame($sformatf("%s_b%0d", tag, k), (k == 0) ? 3 : CPB / 2 + 1, b);
            check($sformatf("%s_byte%0d", tag, k), {24'd0, b}, {24'd0, exp_b[k]});
        end
    endtask

    // Raises cpu_done and keeps hammering the event inputs for the whole dump.
    task automatic dump_with_noise(input string tag);
        cpu_done = 1'b1;
        fork
            recv_dump(tag);
            begin
                repeat (20600) tick(8'($urandom));
            end
        join
    endtask

    task automatic idle_after(input string tag);
        bit low = 1'b0;
        repeat (300) begin
            cpu_done = 1'($urandom);
            tick(8'($urandom));
            if (tx_data !== 1'b1) low = 1'b1;
        end
        check({tag, "_idle_after_done"}, {31'd0, low}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        bit         low;

        ph[0] = '{8'h01, 40};
        ph[1] = '{8'h02, 20};
        ph[2] = '{8'h04, 30};
        ph[3] = '{8'h08, 20};
        ph[4] = '{8'h10, 50};
        ph[5] = '{8'h20, 20};
        ph[6] = '{8'h40, 20};
        dir_cnt = '{40, 20, 30, 20, 50, 20, 20, 0};
        all_cnt = '{300, 300, 300, 300, 300, 300, 300, 300};
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
        mfrozen = 1'b0;

        rstn     = 1'b0;
        cpu_done = 1'b1;
        evt      = 8'h00;
        @(negedge clk);

        // Long reset with cpu_done and events active: line stays idle.
        low = 1'b0;
        repeat (100) begin
            tick(8'($urandom));
            if (tx_data !== 1'b1) low = 1'b1;
        end
        check("reset_idle", {31'd0, low}, 32'd0);
        rstn     = 1'b1;
        cpu_done = 1'b0;
        low = 1'b0;
        repeat (20) begin
            tick(8'h00);
            if (tx_data !== 1'b1) low = 1'b1;
        end
        check("no_trigger_after_reset", {31'd0, low}, 32'd0);

        // Directed phases, then dump with events still toggling.
        for (int p = 0; p < 7; p++) begin
            repeat (ph[p].cycles) tick(ph[p].mask);
        end
        set_exp(dir_cnt);
        dump_with_noise("dir");
        idle_after("dir");

        // Mid-frame reset during a start bit, then restart from byte 0.
        rstn     = 1'b0;
        cpu_done = 1'b0;
        repeat (3) tick(8'h00);
        rstn = 1'b1;
        repeat (60) tick(8'($urandom));
        set_exp(mcnt);
        cpu_done = 1'b1;
        recv_frame("mid_b0", 3, b);
        check("mid_byte0", {24'd0, b}, {24'd0, exp_b[0]});
        recv_frame("mid_b1", CPB / 2 + 1, b);
        check("mid_byte1", {24'd0, b}, {24'd0, exp_b[1]});
        repeat (CPB / 2 + 11) @(negedge clk);
        check("mid_in_start_bit", {31'd0, tx_data}, 32'd0);
        rstn     = 1'b0;
        cpu_done = 1'b0;
        tick(8'h00);
        check("tx_high_after_reset", {31'd0, tx_data}, 32'd1);
        rstn = 1'b1;
        repeat (300) tick(8'hFF);
        set_exp(all_cnt);
        dump_with_noise("all8");

        // Random event mix against the reference model.
        rstn     = 1'b0;
        cpu_done = 1'b0;
        repeat (5) tick(8'h00);
        rstn = 1'b1;
        repeat (500) tick(8'($urandom) & 8'($urandom) | 8'($urandom_range(0, 1) << $urandom_range(0, 7)));
        set_exp(mcnt);
        dump_with_noise("rand");
        idle_after("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
